// File: rtl/ras_ctrl_if.sv
// Bundle of the predict-stage, FTQ-redirect and RAS-storage signals around the
// return-address-stack speculation controller. The master side is the
// BPU/FTQ/RAS environment; the slave side is ras_ctrl itself.
interface ras_ctrl_if #(
  parameter int STACKPTRW  = 4,
  parameter int STACKWIDE  = 32,
  parameter int RECURCOUNT = 7,
  parameter int FTQPTRW    = 3
);
  // predict stage
  logic                              BPUVALID;
  logic [FTQPTRW-1:0]                BPUTAG;
  logic                              BPUCALL;
  logic                              BPURET;
  logic [STACKWIDE-1:0]              BPUADDR;
  logic                              BPUREADY;
  // current RAS view
  logic [STACKPTRW-1:0]              TOPPTR;
  logic [STACKWIDE+RECURCOUNT-1:0]   TOPLINE;
  // FTQ redirect
  logic                              REDIRCT;
  logic [FTQPTRW-1:0]                REDIRTAG;
  logic                              REDIRCALL;
  logic                              REDIRRET;
  logic [STACKWIDE-1:0]              REDIRADDR;
  // RAS update strobes
  logic                              WABLE;
  logic                              RABLE;
  logic [STACKWIDE-1:0]              DIN;
  logic                              RSTVALID;
  logic [STACKPTRW-1:0]              RSTPTR;
  logic [STACKWIDE+RECURCOUNT-1:0]   RSTLINE;
  // status
  logic                              CKPTMISS;
  logic [7:0]                        DROPCNT;

  modport master (
    output BPUVALID, BPUTAG, BPUCALL, BPURET, BPUADDR,
    output TOPPTR, TOPLINE,
    output REDIRCT, REDIRTAG, REDIRCALL, REDIRRET, REDIRADDR,
    input  BPUREADY, WABLE, RABLE, DIN, RSTVALID, RSTPTR, RSTLINE,
    input  CKPTMISS, DROPCNT
  );

  modport slave (
    input  BPUVALID, BPUTAG, BPUCALL, BPURET, BPUADDR,
    input  TOPPTR, TOPLINE,
    input  REDIRCT, REDIRTAG, REDIRCALL, REDIRRET, REDIRADDR,
    output BPUREADY, WABLE, RABLE, DIN, RSTVALID, RSTPTR, RSTLINE,
    output CKPTMISS, DROPCNT
  );
endinterface

// File: rtl/ras_ctrl.sv
// Return-address-stack speculation controller. Converts predicted call/return
// blocks into RAS push/pop strobes, checkpoints {pointer, top line} per FTQ
// entry, and on an FTQ redirect restores the stack from the checkpoint and then
// re-applies the redirecting instruction's own call/return as a fixup.
module ras_ctrl #(
  parameter int STACKDEEP  = 16,
  parameter int STACKPTRW  = 4,
  parameter int STACKWIDE  = 32,
  parameter int RECURCOUNT = 7,
  parameter int FTQDEEP    = 8,
  parameter int FTQPTRW    = 3
) (
  input logic        Clk,
  input logic        Rest,
  ras_ctrl_if.slave  bus
);

  localparam int LINEW = STACKWIDE + RECURCOUNT;
  localparam logic [STACKPTRW-1:0] PTR_FULL  = STACKPTRW'(STACKDEEP - 1);
  localparam logic [STACKPTRW-1:0] PTR_EMPTY = {STACKPTRW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESTORE = 2'd1,
    ST_FIXUP   = 2'd2
  } state_t;

  state_t               state_r;
  logic [STACKPTRW-1:0] ckpt_ptr_r  [FTQDEEP];
  logic [LINEW-1:0]     ckpt_line_r [FTQDEEP];
  logic [FTQDEEP-1:0]   ckpt_vld_r;

  logic [FTQPTRW-1:0]   lat_tag_r;
  logic                 lat_call_r;
  logic                 lat_ret_r;
  logic [STACKWIDE-1:0] lat_addr_r;

  logic                 wable_r;
  logic                 rable_r;
  logic [STACKWIDE-1:0] din_r;
  logic                 rstvalid_r;
  logic [STACKPTRW-1:0] rstptr_r;
  logic [LINEW-1:0]     rstline_r;
  logic                 ckptmiss_r;
  logic [7:0]           dropcnt_r;

  logic                 bpuready_s;
  logic                 accept_s;
  logic                 pred_push_s;
  logic                 pred_pop_s;
  logic [1:0]           pred_drops_s;
  logic                 fix_push_s;
  logic                 fix_pop_s;
  logic [1:0]           fix_drops_s;
  logic                 redir_hit_s;
  logic [FTQDEEP-1:0]   keep_mask_s;

  // Saturating add of a small drop count onto the 8-bit counter.
  function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'd0, inc};
    if (sum > 9'd255) begin
      sat_add = 8'd255;
    end else begin
      sat_add = sum[7:0];
    end
  endfunction

  // Handshake, push/pop decisions for predict and fixup paths, restore lookup.
  always_comb begin
    bpuready_s  = (state_r == ST_IDLE) & ~bus.REDIRCT;
    accept_s    = bus.BPUVALID & bpuready_s;

    // Predict path: a call wins over a simultaneous return.
    pred_push_s  = bus.BPUCALL & (bus.TOPPTR != PTR_FULL);
    pred_pop_s   = bus.BPURET & ~bus.BPUCALL & (bus.TOPPTR != PTR_EMPTY);
    pred_drops_s = {1'b0, bus.BPUCALL & (bus.TOPPTR == PTR_FULL)}
                 + {1'b0, bus.BPUCALL & bus.BPURET}
                 + {1'b0, bus.BPURET & ~bus.BPUCALL & (bus.TOPPTR == PTR_EMPTY)};

    // Fixup path: judged against the pointer just restored.
    fix_push_s   = lat_call_r & (rstptr_r != PTR_FULL);
    fix_pop_s    = lat_ret_r & ~lat_call_r & (rstptr_r != PTR_EMPTY);
    fix_drops_s  = {1'b0, lat_call_r & (rstptr_r == PTR_FULL)}
                 + {1'b0, lat_call_r & lat_ret_r}
                 + {1'b0, lat_ret_r & ~lat_call_r & (rstptr_r == PTR_EMPTY)};

    redir_hit_s  = ckpt_vld_r[bus.REDIRTAG];
    keep_mask_s  = {{(FTQDEEP-1){1'b0}}, 1'b1} << lat_tag_r;
  end

  // Controller state machine: predict accept, restore and fixup sequencing.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_r    <= ST_IDLE;
      ckpt_vld_r <= {FTQDEEP{1'b0}};
      lat_tag_r  <= {FTQPTRW{1'b0}};
      lat_call_r <= 1'b0;
      lat_ret_r  <= 1'b0;
      lat_addr_r <= {STACKWIDE{1'b0}};
      wable_r    <= 1'b0;
      rable_r    <= 1'b0;
      din_r      <= {STACKWIDE{1'b0}};
      rstvalid_r <= 1'b0;
      rstptr_r   <= {STACKPTRW{1'b0}};
      rstline_r  <= {LINEW{1'b0}};
      ckptmiss_r <= 1'b0;
      dropcnt_r  <= 8'd0;
    end else begin
      wable_r    <= 1'b0;
      rable_r    <= 1'b0;
      rstvalid_r <= 1'b0;
      if (bus.REDIRCT) begin
        // A redirect in any state (re)starts the restore and cancels any fixup.
        lat_tag_r  <= bus.REDIRTAG;
        lat_call_r <= bus.REDIRCALL;
        lat_ret_r  <= bus.REDIRRET;
        lat_addr_r <= bus.REDIRADDR;
        state_r    <= ST_RESTORE;
        rstvalid_r <= 1'b1;
        if (redir_hit_s) begin
          rstptr_r  <= ckpt_ptr_r[bus.REDIRTAG];
          rstline_r <= ckpt_line_r[bus.REDIRTAG];
        end else begin
          rstptr_r   <= {STACKPTRW{1'b0}};
          rstline_r  <= {LINEW{1'b0}};
          ckptmiss_r <= 1'b1;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (accept_s) begin
              // Checkpoint holds the stack as it was before this block.
              ckpt_ptr_r[bus.BPUTAG]  <= bus.TOPPTR;
              ckpt_line_r[bus.BPUTAG] <= bus.TOPLINE;
              ckpt_vld_r[bus.BPUTAG]  <= 1'b1;
              wable_r                 <= pred_push_s;
              rable_r                 <= pred_pop_s;
              dropcnt_r               <= sat_add(dropcnt_r, pred_drops_s);
              if (pred_push_s) begin
                din_r <= bus.BPUADDR;
              end
            end
          end
          ST_RESTORE: begin
            // Restore committed: every younger checkpoint is squashed.
            ckpt_vld_r <= ckpt_vld_r & keep_mask_s;
            if (lat_call_r | lat_ret_r) begin
              state_r   <= ST_FIXUP;
              wable_r   <= fix_push_s;
              rable_r   <= fix_pop_s;
              dropcnt_r <= sat_add(dropcnt_r, fix_drops_s);
              if (fix_push_s) begin
                din_r <= lat_addr_r;
              end
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_FIXUP: begin
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.BPUREADY = bpuready_s;
  assign bus.WABLE    = wable_r;
  assign bus.RABLE    = rable_r;
  assign bus.DIN      = din_r;
  assign bus.RSTVALID = rstvalid_r;
  assign bus.RSTPTR   = rstptr_r;
  assign bus.RSTLINE  = rstline_r;
  assign bus.CKPTMISS = ckptmiss_r;
  assign bus.DROPCNT  = dropcnt_r;

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed scoreboard bench for ras_ctrl. The driver pushes the expected RAS
// strobe (kind, cycle, data) whenever it issues stimulus; a monitor pops and
// compares whenever the DUT raises WABLE, RABLE or RSTVALID.
module tb_ras_ctrl;

  logic Clk = 1'b0;
  logic Rest;
  int   tests  = 0;
  int   fails  = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    logic [2:0]  kind;   // {WABLE, RABLE, RSTVALID}
    logic [31:0] din;
    logic [3:0]  ptr;
    logic [38:0] line;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  localparam logic [2:0] K_NONE = 3'b000;
  localparam logic [2:0] K_PUSH = 3'b100;
  localparam logic [2:0] K_POP  = 3'b010;
  localparam logic [2:0] K_RST  = 3'b001;

  ras_ctrl_if bus ();

  ras_ctrl dut (
    .Clk  (Clk),
    .Rest (Rest),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  // cycle counter: number of rising edges seen
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // monitor: compare every strobe against the head of the scoreboard
  always @(negedge Clk) begin
    if (mon_en) begin
      if (bus.WABLE === 1'b1 || bus.RABLE === 1'b1 || bus.RSTVALID === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe: cycle %0d strobes %b, expected none",
                   cyc, {bus.WABLE, bus.RABLE, bus.RSTVALID});
        end else begin
          mon_e = sb.pop_front();
          if (({bus.WABLE, bus.RABLE, bus.RSTVALID} !== mon_e.kind) || (cyc != mon_e.at) ||
              ((mon_e.kind == K_PUSH) && (bus.DIN !== mon_e.din)) ||
              ((mon_e.kind == K_RST) && ({bus.RSTPTR, bus.RSTLINE} !== {mon_e.ptr, mon_e.line}))) begin
            fails++;
            $display("FAIL strobe_check: got cycle %0d strobes %b din %h ptr %0d line %h; expected cycle %0d strobes %b din %h ptr %0d line %h",
                     cyc, {bus.WABLE, bus.RABLE, bus.RSTVALID}, bus.DIN, bus.RSTPTR, bus.RSTLINE,
                     mon_e.at, mon_e.kind, mon_e.din, mon_e.ptr, mon_e.line);
          end
        end
      end else if (sb.size() > 0 && sb[0].at <= cyc) begin
        tests++;
        fails++;
        mon_e = sb.pop_front();
        $display("FAIL missing_strobe: got no strobe at cycle %0d, expected strobes %b at cycle %0d",
                 cyc, mon_e.kind, mon_e.at);
      end
    end
  end

  // one predict-stage block for one cycle; caller supplies the expected strobe
  task automatic accept(input logic [2:0] tag, input logic c, input logic r,
                        input logic [31:0] a, input logic [3:0] tp, input logic [38:0] tl,
                        input logic [2:0] ek);
    bus.BPUVALID = 1'b1;
    bus.BPUTAG   = tag;
    bus.BPUCALL  = c;
    bus.BPURET   = r;
    bus.BPUADDR  = a;
    bus.TOPPTR   = tp;
    bus.TOPLINE  = tl;
    #1;
    chk("bpuready_accept", bus.BPUREADY, 64'd1);
    if (ek != K_NONE) sb.push_back('{ek, a, 4'd0, 39'd0, cyc + 1});
    @(negedge Clk);
    bus.BPUVALID = 1'b0;
    bus.BPUCALL  = 1'b0;
    bus.BPURET   = 1'b0;
  endtask

  // one redirect strobe; expected restore at +1 and optional fixup at +2
  task automatic redirect(input logic [2:0] tag, input logic c, input logic r,
                          input logic [31:0] a, input logic [3:0] ep, input logic [38:0] el,
                          input logic [2:0] fk, input logic [31:0] fdin);
    bus.REDIRCT   = 1'b1;
    bus.REDIRTAG  = tag;
    bus.REDIRCALL = c;
    bus.REDIRRET  = r;
    bus.REDIRADDR = a;
    bus.TOPLINE   = 39'h7F_0000_0000;
    #1;
    chk("bpuready_redirect", bus.BPUREADY, 64'd0);
    sb.push_back('{K_RST, 32'd0, ep, el, cyc + 1});
    if (fk != K_NONE) sb.push_back('{fk, fdin, 4'd0, 39'd0, cyc + 2});
    @(negedge Clk);
    bus.REDIRCT   = 1'b0;
    bus.REDIRCALL = 1'b0;
    bus.REDIRRET  = 1'b0;
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, expected finish");
    $fatal(1);
  end

  initial begin
    Rest          = 1'b1;
    bus.BPUVALID  = 1'b0;
    bus.BPUTAG    = 3'd0;
    bus.BPUCALL   = 1'b0;
    bus.BPURET    = 1'b0;
    bus.BPUADDR   = 32'd0;
    bus.TOPPTR    = 4'd0;
    bus.TOPLINE   = 39'd0;
    bus.REDIRCT   = 1'b0;
    bus.REDIRTAG  = 3'd0;
    bus.REDIRCALL = 1'b0;
    bus.REDIRRET  = 1'b0;
    bus.REDIRADDR = 32'd0;
    repeat (3) @(negedge Clk);
    Rest = 1'b0;
    @(negedge Clk);

    // 1: reset state
    chk("rst_wable",    bus.WABLE,    64'd0);
    chk("rst_rable",    bus.RABLE,    64'd0);
    chk("rst_rstvalid", bus.RSTVALID, 64'd0);
    chk("rst_din",      bus.DIN,      64'd0);
    chk("rst_rstptr",   bus.RSTPTR,   64'd0);
    chk("rst_rstline",  bus.RSTLINE,  64'd0);
    chk("rst_ckptmiss", bus.CKPTMISS, 64'd0);
    chk("rst_dropcnt",  bus.DROPCNT,  64'd0);
    chk("rst_bpuready", bus.BPUREADY, 64'd1);
    mon_en = 1'b1;

    // 2: call accept at TOPPTR=3, tag 2
    accept(3'd2, 1'b1, 1'b0, 32'h1C00_0100, 4'd3, 39'h15_AA55_0102, K_PUSH);

    // 3: redirect tag 2 with return; a block offered in that cycle is refused
    bus.BPUVALID = 1'b1;
    bus.BPUTAG   = 3'd3;
    bus.BPUCALL  = 1'b1;
    bus.BPUADDR  = 32'hDEAD_0000;
    redirect(3'd2, 1'b0, 1'b1, 32'd0, 4'd3, 39'h15_AA55_0102, K_POP, 32'd0);
    bus.BPUVALID = 1'b0;
    bus.BPUCALL  = 1'b0;
    #1;
    chk("bpuready_n1", bus.BPUREADY, 64'd0);
    @(negedge Clk);
    chk("bpuready_n2", bus.BPUREADY, 64'd0);
    @(negedge Clk);
    chk("bpuready_n3", bus.BPUREADY, 64'd1);
    chk("ckptmiss_hit", bus.CKPTMISS, 64'd0);

    // 4: full, empty, and call+ret together
    accept(3'd0, 1'b1, 1'b0, 32'h1111_0000, 4'd15, 39'd1, K_NONE);
    chk("dropcnt_full", bus.DROPCNT, 64'd1);
    accept(3'd6, 1'b0, 1'b1, 32'd0, 4'd0, 39'd2, K_NONE);
    chk("dropcnt_empty", bus.DROPCNT, 64'd2);
    accept(3'd7, 1'b1, 1'b1, 32'h2000_0040, 4'd5, 39'd3, K_PUSH);
    chk("dropcnt_both", bus.DROPCNT, 64'd3);

    // 5: redirect on a never-written tag, no fixup
    redirect(3'd5, 1'b0, 1'b0, 32'd0, 4'd0, 39'd0, K_NONE, 32'd0);
    chk("ckptmiss_set", bus.CKPTMISS, 64'd1);
    chk("bpuready_miss_n1", bus.BPUREADY, 64'd0);
    @(negedge Clk);
    chk("bpuready_miss_n2", bus.BPUREADY, 64'd1);

    // 6: back-to-back redirects; the tag-1 fixup is cancelled
    accept(3'd1, 1'b0, 1'b0, 32'd0, 4'd7, 39'h01_0000_0007, K_NONE);
    accept(3'd4, 1'b0, 1'b0, 32'd0, 4'd9, 39'h04_0000_0009, K_NONE);
    redirect(3'd1, 1'b1, 1'b0, 32'h3000_0000, 4'd7, 39'h01_0000_0007, K_NONE, 32'd0);
    redirect(3'd4, 1'b0, 1'b0, 32'd0, 4'd9, 39'h04_0000_0009, K_NONE, 32'd0);
    @(negedge Clk);
    chk("bpuready_b2b", bus.BPUREADY, 64'd1);
    // tag 4 still valid, tag 1 squashed by the tag-4 restore
    redirect(3'd4, 1'b0, 1'b0, 32'd0, 4'd9, 39'h04_0000_0009, K_NONE, 32'd0);
    @(negedge Clk);
    redirect(3'd1, 1'b0, 1'b0, 32'd0, 4'd0, 39'd0, K_NONE, 32'd0);
    @(negedge Clk);

    // DROPCNT saturation: 260 dropped returns on an empty stack
    for (int i = 0; i < 260; i++) begin
      accept(3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 39'd0, K_NONE);
    end
    chk("dropcnt_sat", bus.DROPCNT, 64'd255);

    repeat (4) @(negedge Clk);
    chk("scoreboard_drained", sb.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
Speculation controller for the return-address stack in the branch-prediction unit. It does three things:
- Turns per-fetch-block call/return predictions into stack push/pop strobes.
- Checkpoints the stack pointer and top line per FTQ entry.
- On an FTQ redirect, runs a restore-then-fixup sequence so the stack matches the redirecting instruction.

It sits between the BPU predict stage, the FTQ and the RAS storage.

Parameters:
STACKDEEP, 16, RAS entries.
STACKPTRW, 4, RAS pointer width.
STACKWIDE, 32, return-address width.
RECURCOUNT, 7, recursion-count field width; a stack line is STACKWIDE+RECURCOUNT bits.
FTQDEEP, 8, FTQ entries, which is also the number of checkpoint slots.
FTQPTRW, 3, FTQ tag width.

Ports:
Clk  in  1  clock
Rest  in  1  reset, synchronous, active-high
BPUVALID  in  1  predict-stage block valid
BPUTAG  in  FTQPTRW  FTQ index of the predicted block
BPUCALL  in  1  block ends in a predicted call
BPURET  in  1  block ends in a predicted return
BPUADDR  in  STACKWIDE  return address to push
BPUREADY  out  1  controller accepts a predict-stage block
TOPPTR  in  STACKPTRW  current RAS pointer
TOPLINE  in  STACKWIDE+RECURCOUNT  current RAS line at TOPPTR-1
REDIRCT  in  1  FTQ redirect strobe
REDIRTAG  in  FTQPTRW  FTQ index of the redirecting block
REDIRCALL  in  1  redirecting instruction is a call
REDIRRET  in  1  redirecting instruction is a return
REDIRADDR  in  STACKWIDE  correct return address for a call fixup
WABLE  out  1  push strobe to RAS
RABLE  out  1  pop strobe to RAS
DIN  out  STACKWIDE  push data
RSTVALID  out  1  restore strobe to RAS
RSTPTR  out  STACKPTRW  pointer to restore
RSTLINE  out  STACKWIDE+RECURCOUNT  top line to restore
CKPTMISS  out  1  sticky: a redirect hit an invalid checkpoint
DROPCNT  out  8  saturating count of dropped push/pop

Behaviour:
Reset (Rest=1 at posedge):
- state=IDLE; all checkpoint valid bits cleared.
- WABLE, RABLE, RSTVALID = 0; DIN, RSTPTR, RSTLINE = 0.
- CKPTMISS = 0; DROPCNT = 0.
- Reset mid-sequence aborts the sequence; no strobes are issued in the following cycle.

Handshake and predict path:
- A block is accepted when BPUVALID & BPUREADY.
- BPUREADY = (state==IDLE) & !REDIRCT, combinational.
- On accept, at that posedge:
  - ckpt[BPUTAG] <= {TOPPTR, TOPLINE}, i.e. the state before the block's own operation.
  - ckptvld[BPUTAG] <= 1.
- A second accept to the same tag overwrites its checkpoint.

Push/pop strobes:
- Registered; one cycle after accept.
- BPUCALL only: WABLE=1, DIN=BPUADDR, unless full (TOPPTR==STACKDEEP-1). When full, no strobe and DROPCNT+1.
- BPURET only: RABLE=1, unless empty (TOPPTR==0). When empty, no strobe and DROPCNT+1.
- BPUCALL & BPURET together: treated as call only; the return is dropped and DROPCNT+1.
- WABLE and RABLE are never high in the same cycle.
- DROPCNT saturates at 255.

State machine (IDLE, RESTORE, FIXUP):
- IDLE -> RESTORE on REDIRCT. Latch REDIRTAG, REDIRCALL, REDIRRET, REDIRADDR.
- A predict-stage block offered in the redirect cycle is not accepted, and no push/pop is issued for it.
- RESTORE, one cycle:
  - RSTVALID=1.
  - If ckptvld[tag]: RSTPTR/RSTLINE come from ckpt[tag].
  - Otherwise: RSTPTR=0, RSTLINE=0, and CKPTMISS set.
  - Next state is FIXUP if the latched call or ret is set, else IDLE.
- FIXUP, one cycle:
  - call: WABLE=1, DIN=latched addr, subject to the full rule against RSTPTR.
  - ret: RABLE=1, subject to the empty rule against RSTPTR.
  - call & ret: treated as call.
  - Next state is IDLE.
- On restore, every checkpoint slot except the redirect tag is invalidated, because those slots are younger and squashed. The redirect tag's slot stays valid.
- REDIRCT in RESTORE or FIXUP restarts at RESTORE with the new latched fields; any pending fixup is cancelled.

Latency, with REDIRCT at cycle N:
- RSTVALID at N+1.
- Fixup strobe at N+2.
- BPUREADY high at N+2 without fixup, N+3 with fixup.
- Predict accept to push/pop strobe: 1 cycle.

Test Plan:
1. Reset, then one cycle with no traffic -> all outputs 0; BPUREADY=1.
2. Call accept:
   - Stimulus: TOPPTR=3, accept tag=2, BPUCALL, BPUADDR=0x1C000100.
   - Response: next cycle WABLE=1, DIN=0x1C000100; ckpt[2]={3, TOPLINE}.
3. Redirect with checkpoint hit:
   - Stimulus: after scenario 2, REDIRCT tag=2, REDIRRET=1.
   - Response: N+1 RSTVALID, RSTPTR=3; N+2 RABLE=1; BPUREADY=0 on N..N+2; BPUREADY=1 at N+3.
4. Full and empty boundaries:
   - Stimulus: call with TOPPTR=15; then return with TOPPTR=0; then call & ret together at TOPPTR=5.
   - Response: no strobe for the first two; DROPCNT increments to 2; the combined case gives WABLE only and DROPCNT=3.
5. Redirect with checkpoint miss:
   - Stimulus: REDIRCT on a never-written tag=5, no call/ret.
   - Response: RSTPTR=0, RSTLINE=0, CKPTMISS=1; back to IDLE at N+2.
6. Back-to-back redirects:
   - Stimulus: REDIRCT tag=1 with call, then REDIRCT tag=4 during the RESTORE cycle.
   - Response: second RSTVALID with ckpt[4]; no WABLE for the tag-1 fixup; only ckptvld[4] remains set.
